// File: rtl/display_buf.sv
// Transmit-side console buffer: 32-entry character FIFO written by the CPU
// output port and drained by an 8N1 UART transmitter onto the tx line.
module display_buf #(
  parameter int clk_freq  = 100_000_000,
  parameter int baud_rate = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] write_data,
  input  logic       DSP_write_en,
  output logic       DSP_ready,
  output logic       buf_full,
  output logic       buf_empty,
  output logic [5:0] buf_count,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [6:0]       mem [32];
  logic [5:0]       wptr;
  logic [5:0]       rptr;
  logic             wr_acc;
  logic             pop;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             tx_n;
  logic             last_tick;

  // Pointer MSB is the wrap bit: equal low bits with differing wrap bits means full.
  assign buf_count = wptr - rptr;
  assign buf_empty = (wptr == rptr);
  assign buf_full  = (wptr[4:0] == rptr[4:0]) && (wptr[5] != rptr[5]);
  assign DSP_ready = ~buf_full;
  assign tx_busy   = (state != IDLE);

  assign wr_acc    = DSP_write_en && !buf_full;
  assign last_tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[4:0]] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= 6'd0;
      rptr <= 6'd0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 6'd1;
      end
      if (pop) begin
        rptr <= rptr + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  // tx_n is the line level for the state being entered, so tx stays a clean register.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n      = 1'b1;
        cnt_n     = '0;
        bit_idx_n = 3'd0;
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_n = {1'b0, mem[rptr[4:0]]};
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (last_tick) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = STOP;
            tx_n      = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (last_tick) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_display_buf.sv
// Directed bench for display_buf: flag table, exact frame waveform, fill/drop,
// simultaneous push/pop, pointer wrap and mid-frame reset.
module tb_display_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] wdata;
  logic       wen;
  logic       ready;
  logic       full;
  logic       empty;
  logic [5:0] count;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  typedef struct {
    logic       wen;
    logic [6:0] d;
    logic       e_empty;
    logic       e_full;
    logic [5:0] e_count;
    logic       e_tx;
    logic       e_busy;
  } vec_t;

  vec_t tbl[6];

  display_buf #(.clk_freq(1_000_000), .baud_rate(100_000)) dut (
    .clk(clk), .reset(reset), .write_data(wdata), .DSP_write_en(wen),
    .DSP_ready(ready), .buf_full(full), .buf_empty(empty),
    .buf_count(count), .tx(tx), .tx_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wen   = 1'b0;
    wdata = 7'd0;
    step();
    reset = 1'b0;
    rxq.delete();
    expq.delete();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && n < budget) begin
      step();
      n++;
    end
    chk(name, {31'd0, (empty === 1'b1 && busy === 1'b0)}, 32'd1);
  endtask

  task automatic chk_stream(input string name);
    int n;
    chk($sformatf("%s_len", name), rxq.size(), expq.size());
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_char%0d", name, i), {24'd0, rxq[i]}, {24'd0, expq[i]});
    end
  endtask

  function automatic logic [6:0] ch(input int i);
    return 7'((i * 37 + 5) & 127);
  endfunction

  // Serial monitor: samples each bit at its midpoint on the falling clock edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (15) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = tx;
          repeat (10) @(negedge clk);
        end
        chk("stop_bit", {31'd0, tx}, 32'd1);
        rxq.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa;
    logic       etx;
    int         bad;
    int         n;

    tbl[0] = '{1'b0, 7'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 7'h41, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 7'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 7'h42, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 7'h43, 1'b0, 1'b0, 6'd2, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 7'h00, 1'b0, 1'b0, 6'd2, 1'b0, 1'b1};

    // Reset values and quiet idle
    do_reset();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    for (int c = 0; c < 50; c++) begin
      step();
      chk("idle_tx", {31'd0, tx}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_empty", {31'd0, empty}, 32'd1);
      chk("idle_count", {26'd0, count}, 32'd0);
    end

    // Table of per-edge inputs and expected post-edge outputs
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wen   = tbl[i].wen;
      wdata = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
      chk($sformatf("tbl%0d_full", i), {31'd0, full}, {31'd0, tbl[i].e_full});
      chk($sformatf("tbl%0d_count", i), {26'd0, count}, {26'd0, tbl[i].e_count});
      chk($sformatf("tbl%0d_tx", i), {31'd0, tx}, {31'd0, tbl[i].e_tx});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end
    wen = 1'b0;
    expq.push_back(8'h41);
    expq.push_back(8'h42);
    expq.push_back(8'h43);
    wait_idle(400, "tbl_drain");
    chk_stream("tbl_stream");

    // Exact waveform of a single 'A' frame
    do_reset();
    fa    = 8'h41;
    wen   = 1'b1;
    wdata = 7'h41;
    step();
    chk("a_empty_after_write", {31'd0, empty}, 32'd0);
    wen = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (c < 10) etx = 1'b0;
      else if (c < 90) etx = fa[(c - 10) / 10];
      else etx = 1'b1;
      if (c == 0) chk("a_empty_after_pop", {31'd0, empty}, 32'd1);
      if (tx !== etx || busy !== 1'b1) begin
        bad++;
        $display("FAIL a_wave cycle %0d actual tx=%b busy=%b required tx=%b busy=1", c, tx, busy, etx);
      end
    end
    chk("a_wave_errors", bad, 0);
    step();
    chk("a_end_busy", {31'd0, busy}, 32'd0);
    chk("a_end_tx", {31'd0, tx}, 32'd1);

    // Fill to 32 while a frame holds the transmitter, 33rd write dropped
    do_reset();
    wen   = 1'b1;
    wdata = 7'h2A;
    step();
    expq.push_back(8'h2A);
    for (int k = 0; k <= 32; k++) begin
      wdata = 7'(7'h30 + k);
      step();
      if (k < 32) expq.push_back({1'b0, 7'(7'h30 + k)});
      if (k == 31) begin
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_ready", {31'd0, ready}, 32'd0);
        chk("fill_count32", {26'd0, count}, 32'd32);
      end
      if (k == 32) chk("fill_drop_count", {26'd0, count}, 32'd32);
    end
    wen = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("fill_idle_seen", {31'd0, busy}, 32'd0);
    chk("fill_count_idle", {26'd0, count}, 32'd32);
    wen   = 1'b1;
    wdata = 7'h51;
    step();
    wen = 1'b0;
    chk("full_pop_count", {26'd0, count}, 32'd31);
    chk("full_pop_ready", {31'd0, ready}, 32'd1);
    chk("full_pop_busy", {31'd0, busy}, 32'd1);
    wait_idle(33 * 101 + 200, "fill_drain");
    chk_stream("fill_stream");

    // Write on the same edge as a pop with five queued
    do_reset();
    for (int k = 0; k < 6; k++) begin
      wen   = 1'b1;
      wdata = 7'(7'h61 + k);
      expq.push_back({1'b0, 7'(7'h61 + k)});
      step();
    end
    wen = 1'b0;
    chk("sim5_count_pre", {26'd0, count}, 32'd5);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("sim5_idle_seen", {31'd0, busy}, 32'd0);
    wen   = 1'b1;
    wdata = 7'h7A;
    expq.push_back(8'h7A);
    step();
    wen = 1'b0;
    chk("sim5_count", {26'd0, count}, 32'd5);
    chk("sim5_busy", {31'd0, busy}, 32'd1);
    wait_idle(7 * 101 + 100, "sim5_drain");
    chk_stream("sim5_stream");

    // 70 characters in bursts of 20 take both pointers past the wrap
    do_reset();
    n = 0;
    for (int b = 0; b < 4; b++) begin
      int len;
      int cyc;
      len = (b < 3) ? 20 : 10;
      bad = 0;
      for (int j = 0; j < len; j++) begin
        wen   = 1'b1;
        wdata = ch(n);
        expq.push_back({1'b0, ch(n)});
        n++;
        step();
        if (count > 6'd20 || full !== 1'b0) bad++;
      end
      wen = 1'b0;
      chk($sformatf("wrap_b%0d_count", b), {26'd0, count}, len - 1);
      cyc = 0;
      while (!(empty === 1'b1 && busy === 1'b0) && cyc < len * 101 + 100) begin
        step();
        cyc++;
        if (count > 6'd20 || full !== 1'b0) bad++;
      end
      chk($sformatf("wrap_b%0d_flags", b), bad, 0);
      chk($sformatf("wrap_b%0d_empty", b), {31'd0, empty}, 32'd1);
      chk($sformatf("wrap_b%0d_zero", b), {26'd0, count}, 32'd0);
    end
    chk_stream("wrap_stream");

    // Reset during DATA bit 3 with four characters queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wen   = 1'b1;
      wdata = (k == 0) ? 7'h37 : 7'(7'h50 + k);
      step();
    end
    wen = 1'b0;
    chk("mid_count_pre", {26'd0, count}, 32'd4);
    repeat (42) step();
    chk("mid_tx_bit3", {31'd0, tx}, 32'd0);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_count", {26'd0, count}, 32'd0);
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    chk("mid_rst_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
